fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch stage feeding the single-cycle core.
//
// Issues word-aligned fetch requests over a req/gnt handshake, collects the
// in-order responses into a DEPTH-entry FIFO tagged with their PCs, and hands
// them to the core over a valid/ready port. A redirect flushes the queue,
// restarts fetch at redirect_pc and discards responses still in flight.
//
// Optional feature: define FETCH_BYPASS_EN to forward an accepted response
// straight to the output when the queue is empty (0-cycle response latency).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_req, mem_addr         fetch request / word address (= fetch_pc)
//   mem_gnt                   request accepted this cycle
//   mem_rvalid, mem_rdata     in-order instruction response
//   redirect, redirect_pc     flush and restart fetch at redirect_pc
//   out_valid, out_ready      head-of-queue handshake to the core
//   out_pc, out_instr         head entry (0 / DEADBEEF when not valid)

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          q [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [31:0]     fetch_pc, resp_pc;
    logic            issue, accept, bypass, q_valid, push, pop;

    // Every queued word plus every in-flight request holds a credit, so the
    // queue can never be asked to accept more than it can hold.
    assign mem_req  = !rst && !redirect &&
                      (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    assign mem_addr = fetch_pc;
    assign issue    = mem_req && mem_gnt;

    // A response is kept only when no stale words are pending and it does
    // not land in a redirect cycle (that one is counted into drop_cnt instead).
    assign accept  = mem_rvalid && (drop_cnt == '0) && !redirect;
    assign q_valid = (count != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && !q_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = q_valid && out_ready;
    // A bypassed word taken by the core the same cycle never enters the queue.
    assign push = accept && !(bypass && out_ready);

    always_comb begin
        out_valid = q_valid || bypass;
        out_pc    = 32'h0;
        out_instr = 32'hDEADBEEF;
        if (q_valid) begin
            out_pc    = q[rd_ptr].pc;
            out_instr = q[rd_ptr].instr;
        end else if (bypass) begin
            out_pc    = resp_pc;
            out_instr = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            // No issue happens in a redirect cycle, so this holds for both paths.
            outstanding <= outstanding + CW'(issue) - CW'(mem_rvalid);
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                // Everything still in flight after this cycle's response is stale.
                drop_cnt <= outstanding - CW'(mem_rvalid);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (mem_rvalid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - 1'b1;
                if (accept)
                    resp_pc <= resp_pc + 32'd4;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (!rst && push)
            q[wr_ptr] <= '{pc: resp_pc, instr: mem_rdata};
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && (count == CW'(DEPTH))));
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int failures = 0;
    int vnum = 0;

    localparam logic [31:0] A = 32'h00400000;
`ifdef FETCH_BYPASS_EN
    localparam logic BP = 1'b1;
`else
    localparam logic BP = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h00400000)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    typedef struct {
        logic        chk;
        logic        rst, gnt, rvalid, redir, ready;
        logic [31:0] rdata, rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t vq[$];

    // Memory contents: every word is its address XOR a fixed pattern.
    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    function automatic vec_t mk(input logic chk, input logic r, input logic gnt,
                                input logic rv, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] rpc,
                                input logic ready, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc);
        vec_t v;
        v.chk = chk; v.rst = r; v.gnt = gnt; v.rvalid = rv; v.rdata = rdata;
        v.redir = redir; v.rpc = rpc; v.ready = ready;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_valid ? e_pc : 32'h0;
        v.e_instr = e_valid ? f(e_pc) : 32'hDEADBEEF;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s: got %h expected %h", vnum, nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        rst = v.rst; mem_gnt = v.gnt; mem_rvalid = v.rvalid; mem_rdata = v.rdata;
        redirect = v.redir; redirect_pc = v.rpc; out_ready = v.ready;
        #1;
        if (v.chk) begin
            cmp("mem_req",   {31'b0, mem_req},   {31'b0, v.e_req});
            cmp("mem_addr",  mem_addr,           v.e_addr);
            cmp("out_valid", {31'b0, out_valid}, {31'b0, v.e_valid});
            cmp("out_pc",    out_pc,             v.e_pc);
            cmp("out_instr", out_instr,          v.e_instr);
        end
        vnum++;
    endtask

    initial begin
        int lag;
        lag = BP ? 0 : 1;

        // Reset, then streaming with 1-cycle memory latency and ready high.
        vq.push_back(mk(1,1,0,0,0,0,0,0, 0,A,0,0));
        vq.push_back(mk(1,1,0,0,0,0,0,0, 0,A,0,0));
        for (int c = 0; c < 12; c++) begin
            logic        rv, ev;
            logic [31:0] rd, epc;
            rv  = (c >= 1);
            rd  = rv ? f(A + 32'(4 * (c - 1))) : 32'h0;
            ev  = (c >= 1 + lag);
            epc = ev ? A + 32'(4 * (c - 1 - lag)) : 32'h0;
            vq.push_back(mk(1,0,1,rv,rd,0,0,1, 1,A + 32'(4 * c),ev,epc));
        end

        // Backpressure: four issues, credits exhausted, then drain.
        vq.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0));
        vq.push_back(mk(1,1,0,0,0,0,0,0, 0,A,0,0));
        vq.push_back(mk(1,0,1,0,0,0,0,0, 1,A,0,0));
        vq.push_back(mk(1,0,1,1,f(A),0,0,0,      1,A+4, BP,A));
        vq.push_back(mk(1,0,1,1,f(A+4),0,0,0,    1,A+8, 1,A));
        vq.push_back(mk(1,0,1,1,f(A+8),0,0,0,    1,A+12,1,A));
        vq.push_back(mk(1,0,1,1,f(A+12),0,0,0,   0,A+16,1,A));
        vq.push_back(mk(1,0,1,0,0,0,0,0,         0,A+16,1,A));
        vq.push_back(mk(1,0,1,0,0,0,0,1,         0,A+16,1,A));
        vq.push_back(mk(1,0,1,0,0,0,0,1,         1,A+16,1,A+4));
        vq.push_back(mk(1,0,1,1,f(A+16),0,0,1,   1,A+20,1,A+8));
        vq.push_back(mk(1,0,1,1,f(A+20),0,0,0,   1,A+24,1,A+12));
        vq.push_back(mk(1,0,1,0,0,0,0,0,         0,A+28,1,A+12));

        foreach (vq[i]) run(vq[i]);

        // Reset with 3 queued and 1 outstanding: restart from RESET_PC.
        run(mk(1,1,0,0,0,0,0,0,       0,A+28,1,A+12));
        run(mk(1,0,1,0,0,0,0,1,       1,A,0,0));
        run(mk(1,0,1,1,f(A),0,0,1,    1,A+4,BP,A));

        // Redirect with 2 in flight and 1 queued; both late words dropped.
        run(mk(0,1,0,0,0,0,0,0,       0,0,0,0));
        run(mk(1,1,0,0,0,0,0,0,       0,A,0,0));
        run(mk(1,0,1,0,0,0,0,0,       1,A,0,0));
        run(mk(1,0,1,1,f(A),0,0,0,    1,A+4,BP,A));
        run(mk(1,0,1,0,0,0,0,0,       1,A+8,1,A));
        run(mk(1,0,1,0,0,1,A+256,0,   0,A+12,1,A));
        run(mk(1,0,1,1,f(A+4),0,0,1,  1,A+256,0,0));
        run(mk(1,0,1,1,f(A+8),0,0,1,  1,A+260,0,0));
        run(mk(1,0,1,1,f(A+256),0,0,1, 1,A+264,BP,A+256));
        run(mk(1,0,1,1,f(A+260),0,0,1, 1,A+268,1,BP ? A+260 : A+256));

        // Redirect coinciding with a response: that response is discarded too.
        run(mk(1,0,1,1,f(A+264),1,A+512,1, 0,A+272,!BP,A+260));
        run(mk(1,0,1,1,f(A+268),0,0,1,     1,A+512,0,0));
        run(mk(1,0,1,1,f(A+512),0,0,1,     1,A+516,BP,A+512));
        // gnt low: address holds, no issue.
        run(mk(1,0,0,0,0,0,0,1,            1,A+520,!BP,A+512));
        run(mk(1,0,0,1,f(A+516),0,0,0,     1,A+520,BP,A+516));
        run(mk(1,0,0,0,0,0,0,1,            1,A+520,1,A+516));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
